// File: rtl/key_schedule_gen.sv
// key_schedule_gen: round-key scheduler for the chaos-based image cipher.
// Holds a 256-entry S-box loaded from the chaotic S-box generator stream.
// Each accepted start expands a seed key over ROUND rounds. Every round does a
// byte-serial S-box substitution, a left byte-rotate and an XOR with an
// LFSR-stepped round-constant word. Each round key is streamed out and is also
// kept in a key bank with a registered random-access read port.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   sbox_valid, sbox_in   S-box load strobe and entry value (written at 0..255 in order)
//   sbox_ready            high once all 256 entries have been loaded
//   start, initial_key    begin expansion of initial_key (accepted in IDLE when ready)
//   busy                  expansion in progress
//   rk_valid/index/data   one-cycle round-key pulse; index/data hold between pulses
//   done                  pulses together with the last rk_valid
//   rd_addr, rd_data      key bank read (0 = seed, r = round r), 1-cycle latency
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; S-box loads are accepted here only
// SUB   | substituting one key byte per cycle, byte 0 first
// MIX   | rotate + round-constant XOR, write bank, emit round key
module key_schedule_gen #(
    parameter int          KEY_SIZE  = 128,
    parameter int          ROUND     = 5,
    parameter int          ROT_BYTES = 4,
    parameter logic [31:0] RC_SEED   = 32'h7AF39C12,
    parameter logic [31:0] RC_POLY   = 32'h04C11DB7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sbox_valid,
    input  logic [7:0]          sbox_in,
    output logic                sbox_ready,
    input  logic                start,
    input  logic [KEY_SIZE-1:0] initial_key,
    output logic                busy,
    output logic                rk_valid,
    output logic [3:0]          rk_index,
    output logic [KEY_SIZE-1:0] rk_data,
    output logic                done,
    input  logic [3:0]          rd_addr,
    output logic [KEY_SIZE-1:0] rd_data
);

    localparam int NB = KEY_SIZE / 8;
    localparam int CW = $clog2(NB);
    localparam int RB = 8 * ROT_BYTES;

    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, MIX = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [7:0]          ptr_q, ptr_d;
    logic                ready_q, ready_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [KEY_SIZE-1:0] sub_q, sub_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          round_q, round_d;
    logic [31:0]         w_q, w_d;
    logic                busy_q, busy_d;
    logic                rk_valid_q, rk_valid_d;
    logic [3:0]          rk_index_q, rk_index_d;
    logic [KEY_SIZE-1:0] rk_data_q, rk_data_d;
    logic                done_q, done_d;
    logic [KEY_SIZE-1:0] rd_data_q, rd_data_d;

    // Storage arrays carry no reset; their contents are reloaded before use.
    // The bank is sized for the full 4-bit address so rd_addr indexes it directly.
    logic [7:0]          tbl_q  [0:255];
    logic [KEY_SIZE-1:0] bank_q [0:15];

    logic                tbl_we;
    logic                bank_we;
    logic [3:0]          bank_waddr;
    logic [KEY_SIZE-1:0] bank_wdata;
    logic [7:0]          cur_byte;
    logic [KEY_SIZE-1:0] mix_key;
    logic [31:0]         w_step;

    assign mix_key = {sub_q[KEY_SIZE-RB-1:0], sub_q[KEY_SIZE-1:KEY_SIZE-RB]}
                     ^ {(KEY_SIZE/32){w_q}};
    assign w_step  = {w_q[30:0], 1'b0} ^ (w_q[31] ? RC_POLY : 32'h0);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ready_d    = ready_q;
        key_d      = key_q;
        sub_d      = sub_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        w_d        = w_q;
        busy_d     = busy_q;
        rk_valid_d = 1'b0;
        rk_index_d = rk_index_q;
        rk_data_d  = rk_data_q;
        done_d     = 1'b0;
        tbl_we     = 1'b0;
        bank_we    = 1'b0;
        bank_waddr = 4'd0;
        bank_wdata = key_q;
        cur_byte   = key_q[cnt_q*8 +: 8];

        // Loads are only taken while idle so the table is stable during SUB.
        if (sbox_valid && state_q == IDLE) begin
            tbl_we = 1'b1;
            ptr_d  = ptr_q + 8'd1;
            if (ptr_q == 8'hFF) begin
                ready_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && ready_q) begin
                    key_d      = initial_key;
                    bank_we    = 1'b1;
                    bank_waddr = 4'd0;
                    bank_wdata = initial_key;
                    round_d    = 4'd1;
                    w_d        = RC_SEED;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = SUB;
                end
            end
            SUB: begin
                sub_d[cnt_q*8 +: 8] = tbl_q[cur_byte];
                if (cnt_q == CW'(NB - 1)) begin
                    state_d = MIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MIX: begin
                key_d      = mix_key;
                bank_we    = 1'b1;
                bank_waddr = round_q;
                bank_wdata = mix_key;
                rk_valid_d = 1'b1;
                rk_index_d = round_q;
                rk_data_d  = mix_key;
                w_d        = w_step;
                cnt_d      = '0;
                if (round_q == 4'(ROUND)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = SUB;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_data_d = (rd_addr <= 4'(ROUND)) ? bank_q[rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= 8'd0;
            ready_q    <= 1'b0;
            key_q      <= '0;
            sub_q      <= '0;
            cnt_q      <= '0;
            round_q    <= 4'd0;
            w_q        <= 32'h0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_index_q <= 4'd0;
            rk_data_q  <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ready_q    <= ready_d;
            key_q      <= key_d;
            sub_q      <= sub_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            w_q        <= w_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
            rk_index_q <= rk_index_d;
            rk_data_q  <= rk_data_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[ptr_q] <= sbox_in;
        end
        if (bank_we) begin
            bank_q[bank_waddr] <= bank_wdata;
        end
    end

    assign sbox_ready = ready_q;
    assign busy       = busy_q;
    assign rk_valid   = rk_valid_q;
    assign rk_index   = rk_index_q;
    assign rk_data    = rk_data_q;
    assign done       = done_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen. Three instances share all inputs:
//   dut_a: RC_SEED=0, RC_POLY=0 (pure substitute + rotate)
//   dut_b: RC_SEED=1, RC_POLY=0 (constant shifts without feedback)
//   dut_c: default constants (LFSR feedback exercised)
module tb_key_schedule_gen;
    localparam int KS = 128;
    localparam logic [KS-1:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, sbox_valid, start;
    logic [7:0]    sbox_in;
    logic [KS-1:0] initial_key;
    logic [3:0]    rd_addr;

    logic          ready_a, busy_a, rkv_a, done_a;
    logic [3:0]    rki_a;
    logic [KS-1:0] rkd_a, rdd_a;
    logic          ready_b, busy_b, rkv_b, done_b;
    logic [3:0]    rki_b;
    logic [KS-1:0] rkd_b, rdd_b;
    logic          ready_c, busy_c, rkv_c, done_c;
    logic [3:0]    rki_c;
    logic [KS-1:0] rkd_c, rdd_c;

    key_schedule_gen #(.KEY_SIZE(KS), .ROUND(5), .ROT_BYTES(4),
                       .RC_SEED(32'h0), .RC_POLY(32'h0)) dut_a (
        .clk(clk), .reset_n(reset_n), .sbox_valid(sbox_valid), .sbox_in(sbox_in),
        .sbox_ready(ready_a), .start(start), .initial_key(initial_key), .busy(busy_a),
        .rk_valid(rkv_a), .rk_index(rki_a), .rk_data(rkd_a), .done(done_a),
        .rd_addr(rd_addr), .rd_data(rdd_a));

    key_schedule_gen #(.KEY_SIZE(KS), .ROUND(5), .ROT_BYTES(4),
                       .RC_SEED(32'h1), .RC_POLY(32'h0)) dut_b (
        .clk(clk), .reset_n(reset_n), .sbox_valid(sbox_valid), .sbox_in(sbox_in),
        .sbox_ready(ready_b), .start(start), .initial_key(initial_key), .busy(busy_b),
        .rk_valid(rkv_b), .rk_index(rki_b), .rk_data(rkd_b), .done(done_b),
        .rd_addr(rd_addr), .rd_data(rdd_b));

    key_schedule_gen #(.KEY_SIZE(KS), .ROUND(5), .ROT_BYTES(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .sbox_valid(sbox_valid), .sbox_in(sbox_in),
        .sbox_ready(ready_c), .start(start), .initial_key(initial_key), .busy(busy_c),
        .rk_valid(rkv_c), .rk_index(rki_c), .rk_data(rkd_c), .done(done_c),
        .rd_addr(rd_addr), .rd_data(rdd_c));

    typedef struct {
        int          ph;
        int          d;
        int          rnd;
        logic [KS-1:0] exp;
    } vec_t;

    vec_t vt[$];

    int errors = 0;
    int checks = 0;

    logic [KS-1:0] cap_a [16];
    logic [KS-1:0] cap_b [16];
    logic [KS-1:0] cap_c [16];
    int            stamp [16];
    int            n_a, done_cnt, done_k;
    logic          busy_at_done, finished;

    task automatic chk(input string nm, input logic [KS-1:0] got, input logic [KS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic load_sbox(input bit inv, input bit check_ready);
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v = 8'(i);
            sbox_valid = 1'b1;
            sbox_in = inv ? ~v : v;
            if (check_ready && i == 255) chk("ready_before_256th", KS'(ready_a), '0);
        end
        @(negedge clk);
        sbox_valid = 1'b0;
        if (check_ready) chk("ready_after_256th", KS'(ready_a), KS'(1));
    endtask

    // Drives start for the cycle T; returns in cycle T+1.
    task automatic do_start(input logic [KS-1:0] key);
        @(negedge clk);
        start = 1'b1;
        initial_key = key;
        @(negedge clk);
        start = 1'b0;
        chk("busy_at_T+1", KS'(busy_a), KS'(1));
    endtask

    // Called in cycle T+1; records pulses with their cycle offset k from T.
    task automatic capture(input bit inject);
        n_a = 0; done_cnt = 0; done_k = 0; busy_at_done = 1'b1; finished = 1'b0;
        for (int r = 0; r < 16; r++) begin
            cap_a[r] = '0; cap_b[r] = '0; cap_c[r] = '0; stamp[r] = 0;
        end
        for (int k = 2; k <= 120 && !finished; k++) begin
            @(negedge clk);
            if (rkv_a) begin
                n_a++;
                cap_a[rki_a] = rkd_a;
                stamp[rki_a] = k;
            end
            if (rkv_b) cap_b[rki_b] = rkd_b;
            if (rkv_c) cap_c[rki_c] = rkd_c;
            if (done_a) begin
                done_cnt++;
                done_k = k;
                busy_at_done = busy_a;
                finished = 1'b1;
            end
            if (inject && k == 5) begin
                start = 1'b1;
                initial_key = ~KEY0;
                sbox_valid = 1'b1;
                sbox_in = 8'hAA;
            end else if (inject && k == 6) begin
                start = 1'b0;
                sbox_valid = 1'b0;
            end
        end
        chk("capture_completed", KS'(finished), KS'(1));
    endtask

    task automatic check_timing(input string tag);
        chk({tag, "_pulse_count"}, KS'(n_a), KS'(5));
        chk({tag, "_round1_latency"}, KS'(stamp[1]), KS'(18));
        for (int r = 2; r <= 5; r++)
            chk($sformatf("%s_spacing_r%0d", tag, r), KS'(stamp[r] - stamp[r-1]), KS'(17));
        chk({tag, "_done_count"}, KS'(done_cnt), KS'(1));
        chk({tag, "_done_with_last"}, KS'(done_k), KS'(stamp[5]));
        chk({tag, "_busy_low_at_done"}, KS'(busy_at_done), '0);
    endtask

    task automatic apply_table(input int ph, input string tag);
        logic [KS-1:0] got;
        foreach (vt[i]) begin
            if (vt[i].ph == ph) begin
                got = (vt[i].d == 0) ? cap_a[vt[i].rnd] :
                      (vt[i].d == 1) ? cap_b[vt[i].rnd] : cap_c[vt[i].rnd];
                chk($sformatf("%s_dut%0d_round%0d", tag, vt[i].d, vt[i].rnd), got, vt[i].exp);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        logic [KS-1:0] flags;
        flags = KS'({busy_a, rkv_a, done_a, ready_a, rki_a,
                     busy_b, rkv_b, done_b, ready_b,
                     busy_c, rkv_c, done_c, ready_c});
        chk({tag, "_ctrl"}, flags, '0);
        chk({tag, "_rk_data"}, rkd_a | rkd_c, '0);
        chk({tag, "_rd_data"}, rdd_a | rdd_c, '0);
    endtask

    logic [KS-1:0] rd_exp [7];
    logic          seen;

    initial begin
        // Phase 4 (dut_a, identity S-box, KEY0): pure rotation by 4r bytes.
        vt.push_back('{4, 0, 1, 128'h0405060708090A0B0C0D0E0F00010203});
        vt.push_back('{4, 0, 2, 128'h08090A0B0C0D0E0F0001020304050607});
        vt.push_back('{4, 0, 3, 128'h0C0D0E0F000102030405060708090A0B});
        vt.push_back('{4, 0, 4, 128'h000102030405060708090A0B0C0D0E0F});
        vt.push_back('{4, 0, 5, 128'h0405060708090A0B0C0D0E0F00010203});
        // Phase 6 (identity S-box, key 0): round keys are the running XOR of W.
        vt.push_back('{6, 1, 1, {4{32'h00000001}}});
        vt.push_back('{6, 1, 2, {4{32'h00000003}}});
        vt.push_back('{6, 1, 3, {4{32'h00000007}}});
        vt.push_back('{6, 1, 4, {4{32'h0000000F}}});
        vt.push_back('{6, 1, 5, {4{32'h0000001F}}});
        vt.push_back('{6, 2, 1, {4{32'h7AF39C12}}});
        vt.push_back('{6, 2, 2, {4{32'h8F14A436}}});
        vt.push_back('{6, 2, 3, {4{32'h601BC9C9}}});
        vt.push_back('{6, 2, 4, {4{32'hBAC40F80}}});
        vt.push_back('{6, 2, 5, {4{32'h0BBA9EA5}}});
        // Phase 7 (dut_a, inverting S-box, key 0).
        vt.push_back('{7, 0, 1, {128{1'b1}}});
        vt.push_back('{7, 0, 2, {128{1'b0}}});

        rd_exp[0] = KEY0;
        for (int r = 1; r <= 5; r++) rd_exp[r] = vt[r-1].exp;
        rd_exp[6] = '0;

        reset_n = 1'b0; sbox_valid = 1'b0; sbox_in = 8'h00; start = 1'b0;
        initial_key = '0; rd_addr = 4'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_reset");

        // Start before the S-box is loaded must be ignored.
        start = 1'b1; initial_key = KEY0;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | busy_a | rkv_a | busy_c;
        end
        chk("start_before_ready_ignored", KS'(seen), '0);

        load_sbox(1'b0, 1'b1);

        // Main run with a start and an S-box write injected while busy.
        do_start(KEY0);
        capture(1'b1);
        check_timing("run1");
        apply_table(4, "run1");

        // Read port sweep, including an address beyond ROUND.
        for (int a = 0; a <= 6; a++) begin
            rd_addr = 4'(a);
            @(negedge clk);
            chk($sformatf("rd_addr%0d", a), rdd_a, rd_exp[a]);
        end
        rd_addr = 4'd0;

        do_start('0);
        capture(1'b0);
        apply_table(6, "rc");

        // If the busy-time write had moved the pointer, this load would be shifted.
        load_sbox(1'b1, 1'b0);
        chk("ready_stays_set", KS'(ready_a), KS'(1));
        do_start('0);
        capture(1'b0);
        apply_table(7, "inv");

        // Reset during round 3, then reload and repeat the main run.
        load_sbox(1'b0, 1'b0);
        do_start(KEY0);
        repeat (39) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_cleared_by_reset", KS'(ready_a | ready_c), '0);
        load_sbox(1'b0, 1'b1);
        do_start(KEY0);
        capture(1'b0);
        check_timing("rerun");
        apply_table(4, "rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_schedule_gen.md
Name: key_schedule_gen

Overview:
Parametrised round-key scheduler for the chaos-based image cipher. It holds its own 256-entry S-box, loaded once from the chaotic S-box generator stream. On each start it expands a seed key over ROUND rounds using byte-serial substitution, a byte-rotate, and an LFSR-generated round constant. It streams every round key out and also stores them in an internal key bank with a random-access read port for the encrypt and decrypt datapaths.

Parameters:
KEY_SIZE, 128, key width in bits; must be a multiple of 32; NB = KEY_SIZE/8 bytes.
ROUND, 5, number of expansion rounds, 1..15.
ROT_BYTES, 4, left byte-rotation per round; 0 < ROT_BYTES < NB.
RC_SEED, 32'h7AF39C12, round-constant word for round 1.
RC_POLY, 32'h04C11DB7, XOR mask used to step the round-constant LFSR.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
sbox_valid  in  1  S-box load strobe, one entry per cycle.
sbox_in  in  8  S-box entry value; entries are written at addresses 0,1,...,255 in order.
sbox_ready  out  1  high once 256 entries are loaded.
start  in  1  begin expansion; sampled only when accepted.
initial_key  in  KEY_SIZE  seed key, sampled on an accepted start.
busy  out  1  expansion in progress.
rk_valid  out  1  one-cycle pulse per round key.
rk_index  out  4  round number of rk_data, 1..ROUND.
rk_data  out  KEY_SIZE  round key.
done  out  1  one-cycle pulse together with the last rk_valid.
rd_addr  in  4  key bank read address; 0 = initial key, r = round r.
rd_data  out  KEY_SIZE  registered read data, 1-cycle latency.

Behaviour:
- Reset values: all outputs 0; load pointer 0; state IDLE. The S-box and key bank contents are not reset and are not relied upon after reset.
- S-box load:
  - Each sbox_valid while not busy writes sbox_in to table[ptr]; ptr increments and wraps 255 to 0.
  - sbox_ready is set on the cycle after the 256th write and stays set until reset. Later writes overwrite entries and take effect on the next start.
  - sbox_valid while busy is ignored and does not move the pointer.
- Start acceptance: start is accepted only when sbox_ready=1 and state=IDLE. Otherwise it is ignored, with no queuing.
- Accepted start at cycle T:
  - The working key is loaded from initial_key and written to bank[0].
  - busy=1 from T+1.
  - The round counter r=1 and the constant word W=RC_SEED.
- States: IDLE -> SUB -> MIX -> SUB ... -> IDLE.
- SUB: NB cycles, one byte per cycle, in order i = 0..NB-1, where byte i = key[8i+7:8i] and sub[i] = table[byte i].
- MIX: one cycle.
  - key_next = rotl_bytes(sub, ROT_BYTES) ^ {KEY_SIZE/32{W}}.
  - rotl_bytes(x, R) = {x[KEY_SIZE-8R-1:0], x[KEY_SIZE-1:KEY_SIZE-8R]}.
  - key_next is written to bank[r] and loaded as the working key.
  - W steps as W <= {W[30:0],1'b0} ^ (W[31] ? RC_POLY : 0).
- Output timing:
  - rk_valid/rk_index/rk_data are registered and appear the cycle after MIX, i.e. for round r at cycle T + r*(NB+1) + 1. Defaults: round 1 at T+18, round 5 at T+86.
  - rk_data/rk_index hold their value between pulses.
- Completion:
  - On round ROUND, done pulses with that rk_valid, and busy falls in the same cycle.
  - A new start is accepted from that cycle onward.
- Read port:
  - rd_data <= bank[rd_addr] every cycle; rd_addr > ROUND returns 0.
  - Reading the entry being written in MIX returns the old value.
- Reset mid-expansion: immediate return to IDLE with busy/rk_valid/done = 0 and sbox_ready = 0. The S-box must be reloaded.

Test Plan:
- Identity S-box (entry i = i), RC_SEED=0, RC_POLY=0, key=128'h000102...0F, start -> round 1 = key rotl 4 bytes = 128'h0405...0F00010203. Round 5 = key rotl 20 bytes = round-1 value. Five rk_valid pulses exactly 17 cycles apart; done with the 5th.
- Identity S-box, RC_SEED=1, RC_POLY=0, key=0 -> round 1 = {4{32'h1}}, round 2 = {4{32'h2}} ^ rotl(round 1) = {4{32'h3}}, round 3 = {4{32'h7}}.
- S-box entry i = ~i, key=0, RC_SEED=0, RC_POLY=0 -> round 1 = all FF, round 2 = all 00.
- Start issued before sbox_ready, and again while busy -> no busy/rk_valid response, no change to an in-flight sequence; sbox_valid while busy does not advance the pointer.
- After completion, rd_addr sweeps 0..5 -> rd_data one cycle later equals initial key then rounds 1..5; rd_addr=6 -> 0.
- Reset asserted during round 3 -> outputs 0 and sbox_ready=0; reload S-box, restart with same key -> results identical to an uninterrupted run.
